instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the RV32I pipeline, directly upstream of the decode stage. It owns the program counter, issues word requests to instruction memory through a valid/ack handshake, and drives the IF/ID pipeline register (instruction, PC, PC+4, valid) that decode consumes. It honours a stall from the hazard unit with a one-entry skid buffer and a redirect (taken branch, JAL, JALR) that flushes wrong-path work.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  decode cannot accept; hold the IF/ID register
- redirect_i  in  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  in  32  redirect target; bits [1:0] are forced to 0
- imem_req_o  out  1  request valid; registered
- imem_addr_o  out  32  word address; stable while imem_req_o is high and no ack has arrived
- imem_ack_i  in  1  request accepted and data valid this cycle; only meaningful when imem_req_o=1
- imem_rdata_i  in  32  instruction word, valid with imem_ack_i
- id_valid_o  out  1  IF/ID holds a real instruction
- id_instr_o  out  32  instruction to decode; NOP 32'h00000013 when invalid
- id_pc_o  out  32  PC of id_instr_o
- id_pc_plus4_o  out  32  id_pc_o + 4, modulo 2^32

## Operation
- hold = stall_i & id_valid_o & ~redirect_i. Redirect always overrides stall.
- FSM states: IDLE (no request), WAIT (request outstanding, result used), DROP (request outstanding, result discarded). imem_req_o = (state != IDLE). imem_addr_o = pc_q.
- IDLE: on redirect_i, pc_q <= target, clear the buffer, go to WAIT. Otherwise go to WAIT when ~hold. Stay in IDLE while hold.
- WAIT with ack and redirect_i: discard the data, pc_q <= target, stay in WAIT.
- WAIT with ack and no redirect: pc_q <= pc_q+4. If hold, write {data, pc} to the skid buffer and go to IDLE. Otherwise pass the data to IF/ID and stay in WAIT.
- WAIT with no ack and redirect_i: latch the target in tgt_q and go to DROP. The address does not change.
- DROP with ack: discard the data, pc_q <= tgt_q, go to WAIT. A further redirect in DROP, with or without ack, overwrites the target; the newest target wins.
- IF/ID update priority:
  1. redirect: valid=0, instr=NOP.
  2. hold: keep the current contents.
  3. buffer valid: load from the buffer and clear it.
  4. WAIT ack: load {rdata, pc_q}.
  5. Otherwise load a bubble (valid=0, NOP).
- The skid buffer holds at most one entry. It is never written while valid, because no request is issued while it is full.
- PC arithmetic is 32-bit and wraps from 0xFFFF_FFFC to 0x0000_0000 silently.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, pc_q=RESET_PC, tgt_q=0
  - imem_req_o=0, imem_addr_o=RESET_PC
  - id_valid_o=0, id_instr_o=32'h00000013, id_pc_o=0, id_pc_plus4_o=4
  - skid buffer empty
- Asserting rst_n mid-request abandons the request; the environment must drop any late ack.
- First imem_req_o: cycle 1 after rst_n release. With a zero-wait memory (ack in the request cycle), the first id_valid_o is in cycle 2.
- Throughput is one instruction per cycle with a zero-wait memory. An N-wait memory gives one instruction per N+1 cycles.
- Fetch latency is ack to id_valid_o in one cycle.
- Redirect to first target request:
  - next cycle if the current request is acked in or before the redirect cycle;
  - otherwise the cycle after the pending ack.
- No instruction is lost or duplicated across any stall pattern.

## Structure
- Shared package cpu_pkg holds:
  - NOP_INSTR = 32'h00000013
  - default RESET_PC
  - fetch_state_t enum {IDLE, WAIT, DROP}
- One sub-module: fetch_skid_buf, a one-entry {instr, pc} buffer with write, read and clear inputs and a valid output.
- FSM, PC and the IF/ID register live in instr_fetch.

## Test plan
- Reset with ack tied to req, memory returning 0x00003f37, 0x02000fe7, 0x00001c63: id_pc_o is 0, 4, 8 in cycles 2, 3, 4 with id_valid_o=1 and matching instructions; id_pc_plus4_o is 4, 8, 12.
- stall_i high for 3 cycles while IF/ID holds PC 0: the IF/ID outputs are frozen. PC 4 is buffered and imem_req_o stays 0 after that ack. On release, PC 4 appears the next cycle, then PC 8; there are no gaps or duplicates.
- redirect_i with target 0x40 in a cycle that also acks PC 8: id_valid_o=0 next cycle and the next request address is 0x40. The PC 8 data never reaches decode.
- 3-wait memory with redirect to 0x100 on the first wait cycle: imem_addr_o is held until the ack and that data is dropped. The next request is 0x100, and id_pc_o=0x100 follows.
- redirect_i and stall_i together while IF/ID is valid: the flush wins, giving id_valid_o=0 and id_instr_o=0x00000013. redirect_pc_i=0x103 yields a fetch address of 0x100.
- rst_n pulsed low during WAIT: all outputs take their reset values immediately. After release, the first request is at RESET_PC and no stale instruction is emitted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I pipeline.
// Used by the fetch stage and its skid buffer.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding slot for a fetch that
// returned while decode was stalled.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_i,
    input  logic        rd_i,
    input  logic        clr_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    // Clear beats write beats read; write only happens when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (wr_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (rd_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC, imem request FSM and the IF/ID
// register, with stall skid buffering and redirect flush.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc_q, id_pc_d;

    logic         hold;
    logic [31:0]  tgt_al;
    logic         buf_wr, buf_rd, buf_clr, buf_valid;
    logic [31:0]  buf_instr, buf_pc;

    assign tgt_al = word_align(redirect_pc_i);
    assign hold   = stall_i & id_valid_q & ~redirect_i;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (buf_wr),
        .rd_i    (buf_rd),
        .clr_i   (buf_clr),
        .instr_i (imem_rdata_i),
        .pc_i    (pc_q),
        .valid_o (buf_valid),
        .instr_o (buf_instr),
        .pc_o    (buf_pc)
    );

    // Request FSM, PC advance and pending-redirect target.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        buf_wr  = 1'b0;
        buf_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    pc_d    = tgt_al;
                    buf_clr = 1'b1;
                    state_d = WAIT;
                end else if (!hold) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack_i) begin
                    if (redirect_i) begin
                        pc_d = tgt_al;
                    end else begin
                        pc_d = pc_q + 32'd4;
                        if (hold) begin
                            buf_wr  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else if (redirect_i) begin
                    tgt_d   = tgt_al;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack_i) begin
                    pc_d    = redirect_i ? tgt_al : tgt_q;
                    state_d = WAIT;
                end else if (redirect_i) begin
                    tgt_d = tgt_al;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // IF/ID next value: flush, hold, drain buffer, fresh data, bubble.
    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        buf_rd     = 1'b0;
        if (redirect_i) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (hold) begin
            id_valid_d = id_valid_q;
        end else if (buf_valid) begin
            id_valid_d = 1'b1;
            id_instr_d = buf_instr;
            id_pc_d    = buf_pc;
            buf_rd     = 1'b1;
        end else if (state_q == WAIT && imem_ack_i) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata_i;
            id_pc_d    = pc_q;
        end else begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    assign imem_req_o    = (state_q != IDLE);
    assign imem_addr_o   = pc_q;
    assign id_valid_o    = id_valid_q;
    assign id_instr_o    = id_instr_q;
    assign id_pc_o       = id_pc_q;
    assign id_pc_plus4_o = id_pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model, program-order
// reference for the decode stream, directed plus random stimulus.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_pc_plus4_o (id_pc_plus4_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Instruction memory contents: a few fixed words, hash elsewhere.
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0: return 32'h0000_3f37;
            32'h4: return 32'h0200_0fe7;
            32'h8: return 32'h0000_1c63;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
        endcase
    endfunction

    // Memory: answers the current request after a number of wait cycles.
    int mem_waits = 0;
    bit mem_rand = 1'b0;
    int left = -1;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            left = -1;
            imem_ack_i = 1'b0;
        end else if (imem_req_o) begin
            if (left < 0)
                left = mem_rand ? int'($urandom_range(0, 3)) : mem_waits;
            if (left == 0) begin
                imem_ack_i = 1'b1;
                imem_rdata_i = mem(imem_addr_o);
                left = -1;
            end else begin
                imem_ack_i = 1'b0;
                imem_rdata_i = $urandom;
                left--;
            end
        end else begin
            imem_ack_i = 1'b0;
            imem_rdata_i = $urandom;
            left = -1;
        end
    end

    // Reference: the decode stream must be the program-order sequence
    // starting at RESET_PC, restarting at each redirect target.
    logic [31:0] m_pc;
    logic        p_valid;
    logic        p_req;
    logic [31:0] p_addr;
    int          idle_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_pc = RESET_PC_DEF;
            p_valid = 1'b0;
            p_req = 1'b0;
            p_addr = '0;
            idle_cnt = 0;
        end else begin
            if (redirect_i) begin
                m_pc = redirect_pc_i & 32'hFFFF_FFFC;
                chk("flush_valid", {31'b0, id_valid_o}, 32'd0);
            end else if (stall_i && p_valid) begin
                chk("hold_valid", {31'b0, id_valid_o}, 32'd1);
            end else if (p_valid) begin
                m_pc = m_pc + 32'd4;
            end
            if (id_valid_o) begin
                chk("stream_pc", id_pc_o, m_pc);
                chk("stream_instr", id_instr_o, mem(m_pc));
                chk("stream_pc4", id_pc_plus4_o, m_pc + 32'd4);
            end else begin
                chk("bubble_nop", id_instr_o, NOP_INSTR);
            end
            if (p_req && !imem_ack_i) begin
                chk("req_held", {31'b0, imem_req_o}, 32'd1);
                chk("addr_held", imem_addr_o, p_addr);
            end
            if (id_valid_o || stall_i) idle_cnt = 0;
            else idle_cnt++;
            if (idle_cnt > 40) begin
                chk("progress", idle_cnt, 32'd0);
                idle_cnt = 0;
            end
            p_valid = id_valid_o;
            p_req = imem_req_o;
            p_addr = imem_addr_o;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req_o}, 32'd0);
        chk({tag, "_addr"}, imem_addr_o, RESET_PC_DEF);
        chk({tag, "_valid"}, {31'b0, id_valid_o}, 32'd0);
        chk({tag, "_instr"}, id_instr_o, NOP_INSTR);
        chk({tag, "_pc"}, id_pc_o, 32'd0);
        chk({tag, "_pc4"}, id_pc_plus4_o, 32'd4);
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc,
                          input logic [31:0] ins);
        chk({tag, "_valid"}, {31'b0, id_valid_o}, 32'd1);
        chk({tag, "_pc"}, id_pc_o, pc);
        chk({tag, "_instr"}, id_instr_o, ins);
        chk({tag, "_pc4"}, id_pc_plus4_o, pc + 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        #1 rst_n = 1'b0;
        #2 chk_reset_vals("rst");

        // zero-wait streaming from reset
        do_reset();
        step();
        chk("c1_req", {31'b0, imem_req_o}, 32'd1);
        chk("c1_addr", imem_addr_o, 32'h0);
        step();
        chk_id("c2", 32'h0, 32'h0000_3f37);
        step();
        chk_id("c3", 32'h4, 32'h0200_0fe7);
        step();
        chk_id("c4", 32'h8, 32'h0000_1c63);

        // three-cycle stall with PC 0 in IF/ID
        do_reset();
        step();
        step();
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_id("stall_hold", 32'h0, 32'h0000_3f37);
            chk("stall_noreq", {31'b0, imem_req_o}, 32'd0);
        end
        stall_i = 1'b0;
        step();
        chk_id("unstall_p4", 32'h4, 32'h0200_0fe7);
        chk("unstall_addr", imem_addr_o, 32'h8);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        redirect_i = 1'b0;
        chk("redir_valid", {31'b0, id_valid_o}, 32'd0);
        chk("redir_nop", id_instr_o, NOP_INSTR);
        chk("redir_addr", imem_addr_o, 32'h40);
        step();
        chk_id("redir_tgt", 32'h40, mem(32'h40));

        // redirect while a 3-wait request is outstanding
        mem_waits = 3;
        do_reset();
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("drop_addr", imem_addr_o, 32'h0);
            chk("drop_req", {31'b0, imem_req_o}, 32'd1);
            step();
        end
        chk("drop_next", imem_addr_o, 32'h100);
        for (int k = 0; k < 4; k++) step();
        chk_id("drop_tgt", 32'h100, mem(32'h100));

        // redirect and stall together while IF/ID is valid
        stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h103;
        step();
        stall_i = 1'b0;
        redirect_i = 1'b0;
        chk("rs_valid", {31'b0, id_valid_o}, 32'd0);
        chk("rs_nop", id_instr_o, NOP_INSTR);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (imem_req_o && imem_addr_o == 32'h100) found = 1'b1;
        end
        chk("rs_addr", {31'b0, found}, 32'd1);

        // reset pulse with a request outstanding
        step();
        chk("pre_rst_req", {31'b0, imem_req_o}, 32'd1);
        rst_n = 1'b0;
        #1 chk_reset_vals("mid_rst");
        mem_waits = 0;
        step();
        rst_n = 1'b1;
        step();
        chk("rel_addr", imem_addr_o, RESET_PC_DEF);
        chk("rel_valid", {31'b0, id_valid_o}, 32'd0);
        step();
        chk_id("rel_first", 32'h0, 32'h0000_3f37);

        // PC wrap at the top of the address space
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        step();
        redirect_i = 1'b0;
        step();
        chk_id("wrap_a", 32'hFFFF_FFF8, mem(32'hFFFF_FFF8));
        step();
        chk_id("wrap_b", 32'hFFFF_FFFC, mem(32'hFFFF_FFFC));
        chk("wrap_pc4", id_pc_plus4_o, 32'h0);
        step();
        chk_id("wrap_c", 32'h0, 32'h0000_3f37);

        // random stalls, redirects and memory latency
        mem_rand = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            step();
            stall_i = ($urandom_range(0, 99) < 30);
            redirect_i = ($urandom_range(0, 99) < 5);
            redirect_pc_i = ($urandom_range(0, 3) == 0)
                ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                : $urandom;
        end
        stall_i = 1'b0;
        redirect_i = 1'b0;
        for (int k = 0; k < 20; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
